// File: rtl/csa_resolve_pipe.sv
// csa_resolve_pipe: carry-propagate stage behind the 32-bit carry-save adder.
// Resolves a redundant (sum, carry) pair into result = sum + (carry << 1).
// The ripple is cut into CHUNK-bit slices with one register per slice.
// An output register sits after the last slice.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The upstream side may move in_sum/in_carry freely while in_valid=0.
// The downstream side holds out_result/out_valid stable while
// out_valid && !out_ready.
// in_ready is combinational from out_valid and out_ready only. It never
// depends on in_valid.
//
// The whole pipe advances together on one global enable (adv). Empty slots
// (bubbles) are not collapsed; they travel through the pipe like data.
module csa_resolve_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_result,
  output logic             busy
);

  localparam int STAGES = WIDTH / CHUNK;

  logic adv;

  // Per-slice pipeline registers. res_q fills from the top: each slice
  // shifts its chunk in at the MSB end, so after the last slice the chunks
  // sit in their natural order.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] cy_q;
  logic [WIDTH-1:0]  res_q [STAGES];

  // Operand bits not yet consumed, right-aligned. The last slice has no
  // successor, so it only keeps the top bit of the shifted carry vector.
  logic [WIDTH-1:0]  a_q [STAGES-1];
  logic [WIDTH:0]    b_q [STAGES-1];
  logic              bt_q;

  // Inputs seen by each slice this cycle.
  logic [STAGES-1:0] v_src;
  logic [STAGES-1:0] cy_src;
  logic [WIDTH-1:0]  a_src   [STAGES];
  logic [WIDTH-1:0]  res_src [STAGES];
  logic [WIDTH:0]    b_src   [STAGES];
  logic [CHUNK:0]    sum     [STAGES];

  // Global advance: the pipe stalls only when a finished result is refused.
  always_comb begin
    adv      = !(out_valid && !out_ready);
    in_ready = adv;
    busy     = out_valid || (|v_q);
  end

  // Route each slice's inputs and add one CHUNK-bit slice per stage.
  always_comb begin
    v_src[0]   = in_valid;
    cy_src[0]  = 1'b0;
    a_src[0]   = in_sum;
    b_src[0]   = {in_carry, 1'b0};
    res_src[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_src[k]   = v_q[k-1];
      cy_src[k]  = cy_q[k-1];
      a_src[k]   = a_q[k-1];
      b_src[k]   = b_q[k-1];
      res_src[k] = res_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      sum[k] = {1'b0, a_src[k][CHUNK-1:0]}
             + {1'b0, b_src[k][CHUNK-1:0]}
             + {{CHUNK{1'b0}}, cy_src[k]};
    end
  end

  // Pipeline and output registers: reset clears everything; otherwise all
  // slots load from their predecessor together whenever adv is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q        <= '0;
      cy_q       <= '0;
      bt_q       <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= v_src[k];
        cy_q[k]  <= sum[k][CHUNK];
        res_q[k] <= {sum[k][CHUNK-1:0], res_src[k][WIDTH-1:CHUNK]};
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        a_q[k] <= {{CHUNK{1'b0}}, a_src[k][WIDTH-1:CHUNK]};
        b_q[k] <= {{CHUNK{1'b0}}, b_src[k][WIDTH:CHUNK]};
      end
      // After the last slice the only unresolved operand bit is b[WIDTH].
      bt_q       <= b_src[STAGES-1][CHUNK];
      out_valid  <= v_q[STAGES-1];
      out_result <= {{1'b0, bt_q} + {1'b0, cy_q[STAGES-1]}, res_q[STAGES-1]};
    end
  end

endmodule

// File: tb/tb_csa_resolve_pipe.sv
// tb_csa_resolve_pipe: randomized and directed bench for csa_resolve_pipe.
// The reference model keeps accepted results in a queue. Each entry is
// stamped with the count of advancing edges at acceptance. The head entry
// is visible at the output once four further advancing edges have passed.
module tb_csa_resolve_pipe;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_sum;
  logic [W-1:0]  in_carry;
  logic          out_valid;
  logic          out_ready;
  logic [W+1:0]  out_result;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  logic [W+1:0]  exp_q[$];
  int unsigned   stamp_q[$];
  int unsigned   adv_cnt = 0;
  int unsigned   taken_cnt = 0;

  csa_resolve_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  // Clock.
  always #5 clk = ~clk;

  // Arithmetic definition of the result.
  function automatic logic [W+1:0] model(input logic [W-1:0] s, input logic [W-1:0] c);
    return {2'b00, s} + ({2'b00, c} << 1);
  endfunction

  function automatic logic m_ov_f();
    return (stamp_q.size() != 0) && (stamp_q[0] + 4 == adv_cnt);
  endfunction

  task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] s, input logic [W-1:0] c, input logic r);
    in_valid  = v;
    in_sum    = s;
    in_carry  = c;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single pair through an empty pipe: check latency and value, then drain.
  task automatic run_single(input string name, input logic [W-1:0] s, input logic [W-1:0] c,
                            input logic [W+1:0] exp);
    int k;
    drive(1'b1, s, c, 1'b1);
    tick();
    drive(1'b0, $urandom, $urandom, 1'b1);
    k = 1;
    while (!out_valid && k < 12) begin
      tick();
      k++;
    end
    check({name, "_latency"}, 34'(k), 34'd5);
    check({name, "_result"}, out_result, exp);
    tick();
  endtask

  // Reference model update on every rising edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      stamp_q.delete();
      adv_cnt <= 0;
    end else begin
      if (!m_ov_f() || out_ready) begin
        if (in_valid) begin
          exp_q.push_back(model(in_sum, in_carry));
          stamp_q.push_back(adv_cnt + 1);
        end
        adv_cnt <= adv_cnt + 1;
      end
      if (m_ov_f() && out_ready) begin
        void'(exp_q.pop_front());
        void'(stamp_q.pop_front());
        taken_cnt <= taken_cnt + 1;
      end
    end
  end

  // Compare process: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (started) begin
      check("out_valid", 34'(out_valid), 34'(m_ov_f()));
      check("in_ready", 34'(in_ready), 34'(!m_ov_f() || out_ready));
      check("busy", 34'(busy), 34'(exp_q.size() != 0));
      if (m_ov_f()) check("out_result", out_result, exp_q[0]);
    end
  end

  // Watchdog.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int unsigned base;
    int sent;
    logic acc;
    logic [W+1:0] held;
    held = '0;

    // Reset.
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;
    check("reset_out_valid", 34'(out_valid), 34'd0);
    check("reset_out_result", out_result, 34'h0);
    check("reset_busy", 34'(busy), 34'd0);
    check("reset_in_ready", 34'(in_ready), 34'd1);

    // Pin the model with hand-computed values.
    check("pin_model_ones", model(32'hFFFF_FFFF, 32'hFFFF_FFFF), 34'h2_FFFF_FFFD);
    check("pin_model_ripple", model(32'h00FF_FFFF, 32'h0000_0001), 34'h0_0100_0001);

    // Directed single pairs.
    run_single("zeros", 32'h0, 32'h0, 34'h0_0000_0000);
    run_single("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34'h2_FFFF_FFFD);
    run_single("ripple", 32'h00FF_FFFF, 32'h0000_0001, 34'h0_0100_0001);
    run_single("top_carry", 32'h0000_0000, 32'h8000_0000, 34'h1_0000_0000);

    // Throughput: 10 back-to-back pairs, results on 10 consecutive cycles.
    for (int j = 1; j <= 16; j++) begin
      if (j <= 10) drive(1'b1, $urandom, $urandom, 1'b1);
      else         drive(1'b0, $urandom, $urandom, 1'b1);
      tick();
      check("tput_out_valid", 34'(out_valid), 34'(j >= 5 && j <= 14));
      check("tput_busy", 34'(busy), 34'(j <= 14));
    end

    // Backpressure: 6 pairs, out_ready low for 3 cycles while out_valid=1.
    base = taken_cnt;
    sent = 0;
    for (int j = 1; j <= 20; j++) begin
      drive(sent < 6, $urandom, $urandom, !(j >= 6 && j <= 8));
      #1;
      if (j >= 6 && j <= 8) begin
        check("bp_in_ready", 34'(in_ready), 34'd0);
        check("bp_out_valid", 34'(out_valid), 34'd1);
        if (j == 6) held = out_result;
        else check("bp_hold", out_result, held);
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
    end
    check("bp_delivered", 34'(taken_cnt - base), 34'd6);

    // Random traffic with random backpressure.
    for (int j = 0; j < 400; j++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 3) != 0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1);
    for (int j = 0; j < 20 && exp_q.size() != 0; j++) tick();
    check("random_drained", 34'(exp_q.size()), 34'd0);
    tick();

    // Reset mid-flight: three pairs discarded, reset wins over a transfer.
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, $urandom, $urandom, 1'b1);
      tick();
    end
    drive(1'b1, $urandom, $urandom, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_out_valid", 34'(out_valid), 34'd0);
    check("rst_out_result", out_result, 34'h0);
    check("rst_busy", 34'(busy), 34'd0);
    drive(1'b0, $urandom, $urandom, 1'b1);
    for (int j = 0; j < 6; j++) begin
      tick();
      check("rst_no_ghost", 34'(out_valid), 34'd0);
    end
    begin
      logic [W-1:0] s;
      logic [W-1:0] c;
      s = $urandom;
      c = $urandom;
      run_single("post_rst", s, c, model(s, c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
